// File: rtl/fexp_seq.sv
// Exponent sequencer: add/sub alignment with one shift pulse per step, mul/div exponent sum, normalise with range check.
// Latency: CALC 1 cycle, ALIGN M cycles, NORM until norm_done, DONE 1 cycle. start is ignored while busy; abort returns to IDLE at once.
module fexp_seq #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 40
) (
    input  logic             __clk,
    input  logic             rst_,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic             abort,
    input  logic             norm_inc,
    input  logic             norm_dec,
    input  logic             norm_done,
    output logic             busy,
    output logic             done,
    output logic             shift_en,
    output logic             swap,
    output logic             g,
    output logic [EXP_W-1:0] exp_r,
    output logic             ovf,
    output logic             unf
);
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(MANT_W + 1);
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] E_MIN = ~E_MAX;
    localparam logic signed [EW-1:0] E_ONE = EW'(1);

    typedef enum logic [2:0] {IDLE, CALC, ALIGN, NORM, DONE} state_t;

    state_t                state_q, state_nxt;
    logic [1:0]            op_q, op_nxt;
    logic signed [EW-1:0]  a_q, a_nxt, b_q, b_nxt, e_q, e_nxt;
    logic [CW-1:0]         cnt_q, cnt_nxt;
    logic                  swap_q, swap_nxt, g_q, g_nxt, ovf_q, ovf_nxt, unf_q, unf_nxt;
    logic signed [EW-1:0]  diff, e_adj;
    logic [EW-1:0]         mag;
    logic                  far;

    // Alignment distance is the magnitude of the exponent difference.
    always_comb begin
        diff = a_q - b_q;
        mag  = diff[EW-1] ? $unsigned(-diff) : $unsigned(diff);
        far  = (mag >= EW'(MANT_W));
        case ({norm_inc, norm_dec})
            2'b10:   e_adj = e_q + E_ONE;
            2'b01:   e_adj = e_q - E_ONE;
            default: e_adj = e_q;
        endcase
    end

    always_comb begin
        state_nxt = state_q;
        op_nxt    = op_q;
        a_nxt     = a_q;
        b_nxt     = b_q;
        e_nxt     = e_q;
        cnt_nxt   = cnt_q;
        swap_nxt  = swap_q;
        g_nxt     = g_q;
        ovf_nxt   = ovf_q;
        unf_nxt   = unf_q;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    op_nxt    = op;
                    a_nxt     = {{2{exp_a[EXP_W-1]}}, exp_a};
                    b_nxt     = {{2{exp_b[EXP_W-1]}}, exp_b};
                    ovf_nxt   = 1'b0;
                    unf_nxt   = 1'b0;
                    state_nxt = CALC;
                end
                CALC: begin
                    state_nxt = NORM;
                    swap_nxt  = 1'b0;
                    g_nxt     = 1'b0;
                    case (op_q)
                        2'b10:   e_nxt = a_q + b_q;
                        2'b11:   e_nxt = a_q - b_q;
                        default: begin
                            swap_nxt = diff[EW-1];
                            g_nxt    = far;
                            e_nxt    = diff[EW-1] ? b_q : a_q;
                            cnt_nxt  = far ? '0 : mag[CW-1:0];
                            if (!far && mag != '0) state_nxt = ALIGN;
                        end
                    endcase
                end
                ALIGN: begin
                    cnt_nxt = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_nxt = NORM;
                end
                NORM: begin
                    e_nxt = e_adj;
                    if (norm_done) begin
                        ovf_nxt   = (e_adj > E_MAX);
                        unf_nxt   = (e_adj < E_MIN);
                        state_nxt = DONE;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge __clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            e_q     <= '0;
            cnt_q   <= '0;
            swap_q  <= 1'b0;
            g_q     <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            op_q    <= op_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            e_q     <= e_nxt;
            cnt_q   <= cnt_nxt;
            swap_q  <= swap_nxt;
            g_q     <= g_nxt;
            ovf_q   <= ovf_nxt;
            unf_q   <= unf_nxt;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign shift_en = (state_q == ALIGN);
    assign swap     = swap_q;
    assign g        = g_q;
    assign exp_r    = e_q[EXP_W-1:0];
    assign ovf      = ovf_q;
    assign unf      = unf_q;
endmodule

// File: tb/tb_fexp_seq.sv
// Randomised and directed bench for fexp_seq against an integer-arithmetic reference model.
module tb_fexp_seq;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 40;

    logic             __clk = 1'b0;
    logic             rst_  = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       op    = '0;
    logic [EXP_W-1:0] exp_a = '0;
    logic [EXP_W-1:0] exp_b = '0;
    logic             abort = 1'b0, norm_inc = 1'b0, norm_dec = 1'b0, norm_done = 1'b0;
    logic             busy, done, shift_en, swap, g, ovf, unf;
    logic [EXP_W-1:0] exp_r;

    int tests = 0;
    int fails = 0;

    fexp_seq #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
        .__clk(__clk), .rst_(rst_), .start(start), .op(op), .exp_a(exp_a), .exp_b(exp_b),
        .abort(abort), .norm_inc(norm_inc), .norm_dec(norm_dec), .norm_done(norm_done),
        .busy(busy), .done(done), .shift_en(shift_en), .swap(swap), .g(g),
        .exp_r(exp_r), .ovf(ovf), .unf(unf)
    );

    always #5 __clk = ~__clk;

    task automatic step;
        @(posedge __clk);
        #1;
    endtask

    // Reference: exponent rules evaluated on plain integers.
    function automatic void model(input int opv, input int av, input int bv, input int n_adj,
                                  input logic [15:0] adjs, input logic [1:0] fadj,
                                  output int pulses, output bit sw, output bit gg,
                                  output int e, output bit ov, output bit un);
        int dd, mm;
        logic [1:0] c;
        dd = av - bv;
        sw = 0; gg = 0; pulses = 0;
        if (opv < 2) begin
            sw = (dd < 0);
            mm = sw ? -dd : dd;
            gg = (mm >= MANT_W);
            e = sw ? bv : av;
            pulses = gg ? 0 : mm;
        end else if (opv == 2) e = av + bv;
        else e = av - bv;
        for (int i = 0; i <= n_adj; i++) begin
            c = (i == n_adj) ? fadj : adjs[2*i +: 2];
            if (c == 2'b10) e = e + 1;
            else if (c == 2'b01) e = e - 1;
        end
        ov = (e > (1 << (EXP_W - 1)) - 1);
        un = (e < -(1 << (EXP_W - 1)));
    endfunction

    // Drives one full operation and returns what the DUT showed; proto_ok collects handshake timing.
    task automatic run_op(input logic [1:0] o, input logic [EXP_W-1:0] a, input logic [EXP_W-1:0] b,
                          input int n_adj, input logic [15:0] adjs, input logic [1:0] fadj,
                          output int pulses, output bit proto_ok,
                          output logic sw, output logic gg, output logic [EXP_W-1:0] er,
                          output logic ov, output logic un);
        start = 1'b1; op = o; exp_a = a; exp_b = b;
        step;
        start = 1'b0;
        proto_ok = busy && !shift_en && !done;
        step;
        pulses = 0;
        while (shift_en && pulses < 300) begin
            pulses++;
            step;
        end
        for (int i = 0; i < n_adj; i++) begin
            {norm_inc, norm_dec} = adjs[2*i +: 2];
            proto_ok &= busy && !shift_en && !done;
            step;
        end
        {norm_inc, norm_dec} = fadj;
        norm_done = 1'b1;
        proto_ok &= busy && !shift_en && !done;
        step;
        {norm_inc, norm_dec, norm_done} = 3'b000;
        proto_ok &= done && busy;
        step;
        proto_ok &= !done && !busy;
        sw = swap; gg = g; er = exp_r; ov = ovf; un = unf;
    endtask

    task automatic check_op(input string name, input logic [1:0] o, input int av, input int bv,
                            input int n_adj, input logic [15:0] adjs, input logic [1:0] fadj);
        int p, ep, ee;
        bit pr, esw, eg, eov, eun;
        logic sw, gg, ov, un;
        logic [EXP_W-1:0] er, exp_er;
        model(int'(o), av, bv, n_adj, adjs, fadj, ep, esw, eg, ee, eov, eun);
        run_op(o, EXP_W'(av), EXP_W'(bv), n_adj, adjs, fadj, p, pr, sw, gg, er, ov, un);
        exp_er = ee[EXP_W-1:0];
        tests++;
        if (p !== ep || pr !== 1'b1 || sw !== esw || gg !== eg || er !== exp_er || ov !== eov || un !== eun) begin
            fails++;
            $display("FAIL %s op=%0d a=%0d b=%0d: pulses=%0d/%0d proto=%0b swap=%0b/%0b g=%0b/%0b exp_r=%h/%h ovf=%0b/%0b unf=%0b/%0b",
                     name, o, av, bv, p, ep, pr, sw, esw, gg, eg, er, exp_er, ov, eov, un, eun);
        end
    endtask

    task automatic test_reset;
        tests++;
        if ({busy, done, shift_en, swap, g, ovf, unf} !== 7'b0 || exp_r !== '0) begin
            fails++;
            $display("FAIL reset_state: busy=%b done=%b shift_en=%b swap=%b g=%b exp_r=%h ovf=%b unf=%b want all 0",
                     busy, done, shift_en, swap, g, exp_r, ovf, unf);
        end
    endtask

    task automatic test_align;
        check_op("add_5_2", 2'b00, 5, 2, 0, 16'h0, 2'b00);
        check_op("sub_far_g", 2'b01, -10, 35, 0, 16'h0, 2'b00);
        check_op("sub_m39", 2'b01, -4, 35, 0, 16'h0, 2'b00);
        check_op("add_m40_boundary", 2'b00, 40, 0, 0, 16'h0, 2'b00);
        check_op("add_m0_min_latency", 2'b00, 7, 7, 0, 16'h0, 2'b00);
    endtask

    task automatic test_range;
        check_op("mul_ovf", 2'b10, 100, 50, 0, 16'h0, 2'b00);
        check_op("div_unf", 2'b11, -100, 28, 1, 16'h1, 2'b00);
        check_op("mul_max_edge", 2'b10, 127, 0, 0, 16'h0, 2'b00);
        check_op("div_min_edge", 2'b11, -100, 28, 0, 16'h0, 2'b00);
        check_op("mul_inc_to_ovf", 2'b10, 127, 0, 0, 16'h0, 2'b10);
    endtask

    task automatic test_norm_adjust;
        check_op("norm_both_then_inc", 2'b00, 20, 18, 1, 16'h3, 2'b10);
    endtask

    task automatic test_abort;
        int n;
        start = 1'b1; op = 2'b00; exp_a = 8'd30; exp_b = 8'd0;
        step;
        start = 1'b0;
        step;
        n = 0;
        while (shift_en && n < 5) begin
            n++;
            if (n == 5) abort = 1'b1;
            step;
        end
        abort = 1'b0;
        tests++;
        if (n !== 5 || shift_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort: pulses=%0d want 5, shift_en=%b busy=%b done=%b want 0", n, shift_en, busy, done);
        end
        check_op("after_abort", 2'b00, 5, 2, 0, 16'h0, 2'b00);
    endtask

    task automatic test_busy_start;
        int n;
        start = 1'b1; op = 2'b00; exp_a = 8'd5; exp_b = 8'd2;
        step;
        exp_a = 8'd0; exp_b = 8'd30; op = 2'b10;
        step;
        step;
        start = 1'b0;
        n = 1;
        while (shift_en && n < 300) begin n++; step; end
        norm_done = 1'b1;
        step;
        norm_done = 1'b0;
        tests++;
        if (n !== 3 || done !== 1'b1 || exp_r !== 8'd5 || swap !== 1'b0) begin
            fails++;
            $display("FAIL busy_start: pulses=%0d want 3, done=%b want 1, exp_r=%h want 05, swap=%b want 0", n, done, exp_r, swap);
        end
        step;
    endtask

    task automatic test_reset_mid;
        start = 1'b1; op = 2'b01; exp_a = 8'd0; exp_b = 8'd30;
        step;
        start = 1'b0;
        step; step; step;
        rst_ = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || shift_en !== 1'b0 || done !== 1'b0 || exp_r !== '0 || swap !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_align: busy=%b shift_en=%b done=%b exp_r=%h swap=%b want 0", busy, shift_en, done, exp_r, swap);
        end
        #2 rst_ = 1'b1;
        step;
        check_op("after_reset", 2'b01, 12, -3, 0, 16'h0, 2'b00);
    endtask

    task automatic test_random;
        int av, bv, na;
        logic [1:0] o, fa;
        logic [15:0] adj;
        for (int i = 0; i < 40; i++) begin
            o   = 2'($urandom_range(0, 3));
            av  = $urandom_range(0, 255) - 128;
            bv  = (o < 2) ? av + $urandom_range(0, 90) - 45 : $urandom_range(0, 255) - 128;
            if (bv > 127) bv = 127;
            if (bv < -128) bv = -128;
            na  = $urandom_range(0, 4);
            adj = 16'($urandom);
            fa  = 2'($urandom);
            check_op("random", o, av, bv, na, adj, fa);
        end
    endtask

    initial begin
        #3;
        test_reset;
        rst_ = 1'b1;
        step;
        test_align;
        test_range;
        test_norm_adjust;
        test_abort;
        test_busy_start;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
